// File: rtl/adc_sample_sequencer.sv
// Paced single-channel ADC command initiator: one conversion per sample tick, response capture
// into a first-word fall-through sample FIFO, and sticky overrun/channel/timeout flags.
module adc_sample_sequencer #(
   parameter int CLK_DIV    = 1250,
   parameter int CHANNEL    = 0,
   parameter int DATA_W     = 12,
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT    = 64
) (
   input  logic              clk,
   input  logic              rst_i,
   input  logic              enable_i,
   output logic              command_valid,
   output logic [4:0]        command_channel,
   output logic              command_startofpacket,
   output logic              command_endofpacket,
   input  logic              command_ready,
   input  logic              response_valid,
   input  logic [4:0]        response_channel,
   input  logic [DATA_W-1:0] response_data,
   output logic [DATA_W-1:0] sample_data_o,
   output logic              sample_valid_o,
   input  logic              sample_ready_i,
   output logic              overrun_o,
   output logic              chan_err_o,
   output logic              timeout_o,
   input  logic              clear_i,
   output logic [1:0]        state_o
);

   localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FCNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0]  TICK_RELOAD = CNT_W'(CLK_DIV - 1);
   localparam logic [TMR_W-1:0]  TMR_LAST    = TMR_W'(TIMEOUT - 1);
   localparam logic [FCNT_W-1:0] FIFO_FULL   = FCNT_W'(FIFO_DEPTH);
   localparam logic [4:0]        CHAN        = 5'(CHANNEL);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [FCNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic              overrun_q, overrun_d;
   logic              chan_err_q, chan_err_d;
   logic              timeout_q, timeout_d;

   logic tick;
   logic tick_drop;
   logic push;
   logic push_ok;
   logic push_drop;
   logic pop;
   logic chan_ev;
   logic timeout_ev;

   // Sample-rate divider: counts down while enabled, parked at the reload value when disabled.
   always_comb begin
      tick       = enable_i && (tick_cnt_q == '0);
      tick_cnt_d = tick_cnt_q - CNT_W'(1);
      if (!enable_i || tick) begin
         tick_cnt_d = TICK_RELOAD;
      end
   end

   // Handshakes: a command transfers on a cycle where command_valid && command_ready; the
   // command fields stay stable until then. A response is a single-cycle strobe with no
   // backpressure. A sample transfers on a cycle where sample_valid_o && sample_ready_i.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      tick_drop  = 1'b0;
      push       = 1'b0;
      chan_ev    = 1'b0;
      timeout_ev = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tick) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            tick_drop = tick;
            if (command_ready) begin
               state_d = ST_WAIT;
               timer_d = '0;
            end
         end
         ST_WAIT: begin
            tick_drop = tick;
            timer_d   = timer_q + TMR_W'(1);
            if (response_valid && (response_channel == CHAN)) begin
               push    = 1'b1;
               state_d = ST_IDLE;
            end else begin
               chan_ev = response_valid;
               if (timer_q == TMR_LAST) begin
                  timeout_ev = 1'b1;
                  state_d    = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands.
   always_comb begin
      pop        = sample_valid_o && sample_ready_i;
      push_ok    = push && ((fifo_cnt_q != FIFO_FULL) || pop);
      push_drop  = push && !push_ok;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + FCNT_W'(1);
         2'b01:   fifo_cnt_d = fifo_cnt_q - FCNT_W'(1);
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
   end

   // Sticky flags: a new event in the clearing cycle keeps the flag set.
   always_comb begin
      overrun_d  = (overrun_q & ~clear_i) | tick_drop | push_drop;
      chan_err_d = (chan_err_q & ~clear_i) | chan_ev;
      timeout_d  = (timeout_q & ~clear_i) | timeout_ev;
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         tick_cnt_q <= TICK_RELOAD;
         timer_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         overrun_q  <= 1'b0;
         chan_err_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         timer_q    <= timer_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
         overrun_q  <= overrun_d;
         chan_err_q <= chan_err_d;
         timeout_q  <= timeout_d;
      end
   end

   // Storage needs no reset: the occupancy count alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push_ok && !rst_i) begin
         mem_q[wr_ptr_q] <= response_data;
      end
   end

   assign command_valid         = (state_q == ST_ISSUE);
   assign command_channel       = command_valid ? CHAN : 5'd0;
   assign command_startofpacket = command_valid;
   assign command_endofpacket   = command_valid;
   assign sample_valid_o        = (fifo_cnt_q != '0);
   assign sample_data_o         = sample_valid_o ? mem_q[rd_ptr_q] : '0;
   assign overrun_o             = overrun_q;
   assign chan_err_o            = chan_err_q;
   assign timeout_o             = timeout_q;
   assign state_o               = state_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Randomized bench for adc_sample_sequencer with an ADC responder and a cycle-level
// reference model built from the sequencing rules (tick arithmetic, sample queue, flag events).
module tb_adc_sample_sequencer;

   localparam int CLK_DIV    = 16;
   localparam int CHANNEL    = 0;
   localparam int DATA_W     = 12;
   localparam int FIFO_DEPTH = 4;
   localparam int TIMEOUT    = 8;

   logic              clk;
   logic              rst_i;
   logic              enable_i;
   logic              command_valid;
   logic [4:0]        command_channel;
   logic              command_startofpacket;
   logic              command_endofpacket;
   logic              command_ready;
   logic              response_valid;
   logic [4:0]        response_channel;
   logic [DATA_W-1:0] response_data;
   logic [DATA_W-1:0] sample_data_o;
   logic              sample_valid_o;
   logic              sample_ready_i;
   logic              overrun_o;
   logic              chan_err_o;
   logic              timeout_o;
   logic              clear_i;
   logic [1:0]        state_o;

   adc_sample_sequencer #(
      .CLK_DIV    (CLK_DIV),
      .CHANNEL    (CHANNEL),
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk                   (clk),
      .rst_i                 (rst_i),
      .enable_i              (enable_i),
      .command_valid         (command_valid),
      .command_channel       (command_channel),
      .command_startofpacket (command_startofpacket),
      .command_endofpacket   (command_endofpacket),
      .command_ready         (command_ready),
      .response_valid        (response_valid),
      .response_channel      (response_channel),
      .response_data         (response_data),
      .sample_data_o         (sample_data_o),
      .sample_valid_o        (sample_valid_o),
      .sample_ready_i        (sample_ready_i),
      .overrun_o             (overrun_o),
      .chan_err_o            (chan_err_o),
      .timeout_o             (timeout_o),
      .clear_i               (clear_i),
      .state_o               (state_o)
   );

   // clock/reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "time limit");
   end

   int n_tests = 0;
   int n_fail  = 0;

   // stimulus knobs
   bit k_en       = 1'b0;
   int k_hold_lo  = 0, k_hold_hi = 0;
   int k_lat_lo   = 3, k_lat_hi  = 3;
   bit k_fixed    = 1'b0;
   int k_bad_pct  = 0;
   bit k_no_resp  = 1'b0;
   int k_srdy     = 0;
   int k_clr_pct  = 0;
   int k_stale    = 0;
   bit force_rst  = 1'b0;
   bit force_clr  = 1'b0;
   bit force_late = 1'b0;

   // reference model state
   bit                m_cmd = 1'b0;
   bit                m_aw  = 1'b0;
   int                m_waited = 0;
   int                m_cmd_age = 0;
   int                m_en_cyc = 0;
   bit                m_ovr = 1'b0, m_ch = 1'b0, m_to = 1'b0;
   bit                m_just_reset = 1'b0;
   logic [DATA_W-1:0] exp_q[$];

   // per-command ADC behaviour
   int                cur_hold = 0, cur_lat = 3, cur_bad_at = 0;
   logic [DATA_W-1:0] cur_data = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("cmd_valid", 32'(command_valid), 32'(m_cmd));
      chk("cmd_sop", 32'(command_startofpacket), 32'(m_cmd));
      chk("cmd_eop", 32'(command_endofpacket), 32'(m_cmd));
      chk("cmd_chan", 32'(command_channel), m_cmd ? 32'(CHANNEL) : 32'd0);
      chk("smp_valid", 32'(sample_valid_o), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("smp_data", 32'(sample_data_o), 32'(exp_q[0]));
      if (m_just_reset) chk("rst_data", 32'(sample_data_o), 32'd0);
      chk("overrun", 32'(overrun_o), 32'(m_ovr));
      chk("chan_err", 32'(chan_err_o), 32'(m_ch));
      chk("timeout", 32'(timeout_o), 32'(m_to));
   endtask

   // driver: inputs for this cycle, decided from the model's view of the handshake
   task automatic drive_inputs();
      rst_i    = force_rst;
      enable_i = k_en;
      clear_i  = force_clr || ($urandom_range(0, 99) < k_clr_pct);
      case (k_srdy)
         0:       sample_ready_i = 1'b1;
         1:       sample_ready_i = 1'b0;
         default: sample_ready_i = 1'($urandom_range(0, 1));
      endcase
      command_ready    = m_cmd ? (m_cmd_age >= cur_hold) : 1'($urandom_range(0, 1));
      response_valid   = 1'b0;
      response_channel = 5'($urandom_range(0, 31));
      response_data    = DATA_W'($urandom_range(0, 4095));
      if (m_aw && !k_no_resp) begin
         if (m_waited == cur_lat) begin
            response_valid   = 1'b1;
            response_channel = 5'(CHANNEL);
            response_data    = cur_data;
         end else if (cur_bad_at != 0 && m_waited == cur_bad_at) begin
            response_valid   = 1'b1;
            response_channel = 5'($urandom_range(1, 31));
         end
      end else if (!m_aw && $urandom_range(0, 99) < k_stale) begin
         response_valid = 1'b1;
      end
      if (force_late) begin
         response_valid   = 1'b1;
         response_channel = 5'(CHANNEL);
      end
   endtask

   task automatic new_command();
      cur_hold   = $urandom_range(k_hold_lo, k_hold_hi);
      cur_lat    = $urandom_range(k_lat_lo, k_lat_hi);
      cur_data   = k_fixed ? DATA_W'(12'h5A3) : DATA_W'($urandom_range(0, 4095));
      cur_bad_at = 0;
      if (cur_lat >= 2 && $urandom_range(0, 99) < k_bad_pct) cur_bad_at = $urandom_range(1, cur_lat - 1);
   endtask

   // reference model: one clock of the sequencing rules
   task automatic model_update();
      bit tick, push, ev_ovr, ev_ch, ev_to;
      logic [DATA_W-1:0] pdata;
      if (rst_i) begin
         m_cmd = 1'b0; m_aw = 1'b0; m_waited = 0; m_en_cyc = 0;
         m_ovr = 1'b0; m_ch = 1'b0; m_to = 1'b0;
         exp_q.delete();
         m_just_reset = 1'b1;
         return;
      end
      m_just_reset = 1'b0;
      tick     = enable_i && ((m_en_cyc % CLK_DIV) == CLK_DIV - 1);
      m_en_cyc = enable_i ? m_en_cyc + 1 : 0;
      push = 1'b0; ev_ovr = 1'b0; ev_ch = 1'b0; ev_to = 1'b0; pdata = '0;
      if ((m_cmd || m_aw) && tick) ev_ovr = 1'b1;
      if (m_cmd) begin
         if (command_ready) begin
            m_cmd = 1'b0; m_aw = 1'b1; m_waited = 1;
         end else begin
            m_cmd_age++;
         end
      end else if (m_aw) begin
         if (response_valid && response_channel == 5'(CHANNEL)) begin
            push = 1'b1; pdata = response_data; m_aw = 1'b0;
         end else begin
            if (response_valid) ev_ch = 1'b1;
            if (m_waited == TIMEOUT) begin
               ev_to = 1'b1; m_aw = 1'b0;
            end else begin
               m_waited++;
            end
         end
      end else if (tick) begin
         m_cmd = 1'b1; m_cmd_age = 0;
         new_command();
      end
      if (sample_ready_i && exp_q.size() != 0) void'(exp_q.pop_front());
      if (push) begin
         if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(pdata);
         else ev_ovr = 1'b1;
      end
      m_ovr = (m_ovr && !clear_i) || ev_ovr;
      m_ch  = (m_ch && !clear_i) || ev_ch;
      m_to  = (m_to && !clear_i) || ev_to;
   endtask

   task automatic step_cycle();
      @(negedge clk);
      check_outputs();
      drive_inputs();
      model_update();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step_cycle();
   endtask

   initial begin
      bit reached;
      rst_i = 1'b1; enable_i = 1'b0; clear_i = 1'b0; command_ready = 1'b0;
      response_valid = 1'b0; response_channel = '0; response_data = '0; sample_ready_i = 1'b1;
      model_update();
      force_rst = 1'b1;
      run(2);
      force_rst = 1'b0;
      run(3);

      // steady sampling, fixed data, immediate accept
      k_en = 1'b1; k_fixed = 1'b1; k_hold_lo = 0; k_hold_hi = 0; k_lat_lo = 3; k_lat_hi = 3;
      run(5 * CLK_DIV);
      // command backpressure
      k_fixed = 1'b0; k_hold_lo = 5; k_hold_hi = 5;
      run(3 * CLK_DIV);
      // downstream stall fills the FIFO, then drain
      k_hold_lo = 0; k_hold_hi = 0; k_srdy = 1;
      run(6 * CLK_DIV);
      k_srdy = 0;
      run(4 * CLK_DIV);
      // wrong-channel response precedes the real one
      k_bad_pct = 100;
      run(3 * CLK_DIV);
      k_bad_pct = 0;
      // ADC silent
      k_no_resp = 1'b1;
      run(3 * CLK_DIV);
      k_no_resp = 1'b0;
      run(CLK_DIV);
      force_clr = 1'b1;
      run(1);
      force_clr = 1'b0;
      run(4);

      // randomized blocks
      for (int b = 0; b < 40; b++) begin
         k_en      = ($urandom_range(0, 9) != 0);
         k_hold_lo = 0;
         k_hold_hi = $urandom_range(0, 12);
         k_lat_lo  = 1;
         k_lat_hi  = $urandom_range(1, 10);
         k_bad_pct = $urandom_range(0, 1) ? 30 : 0;
         k_srdy    = $urandom_range(0, 2);
         k_clr_pct = 5;
         k_stale   = 10;
         run(CLK_DIV);
      end

      // reset during a wait with two samples queued, then a late response
      k_en = 1'b1; k_hold_lo = 0; k_hold_hi = 0; k_lat_lo = 7; k_lat_hi = 7;
      k_bad_pct = 0; k_clr_pct = 0; k_stale = 0; k_srdy = 0;
      run(4 * CLK_DIV);
      k_srdy = 1;
      reached = 1'b0;
      for (int i = 0; i < 200 && !reached; i++) begin
         step_cycle();
         reached = (exp_q.size() == 2) && m_aw && (m_waited == 2);
      end
      chk("s6_setup", 32'(reached), 32'd1);
      force_rst = 1'b1;
      run(1);
      force_rst = 1'b0; force_late = 1'b1;
      run(1);
      force_late = 1'b0; k_srdy = 0;
      run(3 * CLK_DIV);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
